// File: rtl/uart_tx_cfg.sv
// UART transmitter with a configurable word width. A frame is a start bit, DATA_W data bits sent LSB first,
// an optional parity bit and 1 or 2 stop bits. The parity and stop modes are latched for each frame on accept.
module uart_tx_cfg #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              tx,
  output logic              busy
);

  // state  | meaning
  // IDLE   | line high, ready for a word
  // START  | start bit (low)
  // DATA   | data bits, LSB first, from shreg[0]
  // PARITY | latched parity bit
  // STOP   | one or two high stop bits

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nx;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit, par_en, stop2;
  logic              tx_nx, accept, bit_end, stop_last;

  assign tx_ready  = rst && (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign stop_last = stop2 ? (bit_cnt == BIT_W'(1)) : (bit_cnt == '0);

  always_comb begin
    state_nx = state;
    tx_nx    = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        tx_nx = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx_nx = shreg[0];
        if (bit_end && (bit_cnt == BIT_LAST)) state_nx = par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx_nx = par_bit;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (bit_end && stop_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the state by one clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      stop2    <= 1'b0;
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
      if ((state == IDLE) || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state_nx != state) bit_cnt <= '0;
      else if (bit_end)      bit_cnt <= bit_cnt + 1'b1;
      if (accept) begin
        shreg   <= tx_data;
        par_bit <= (parity_mode == 2'b10) ? ~^tx_data : ^tx_data;
        par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        stop2   <= two_stop;
      end else if ((state == DATA) && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a frame-level model checks tx/busy/tx_ready on every cycle for two configurations,
// and directed frames are checked against hand-computed decoded words and frame lengths.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst8, tx_valid8, tx_ready8, two_stop8, tx8, busy8;
  logic [7:0] tx_data8;
  logic [1:0] parity8;
  logic       rst5, tx_valid5, tx_ready5, two_stop5, tx5, busy5;
  logic [4:0] tx_data5;
  logic [1:0] parity5;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(434)) dut8 (
    .clk(clk), .rst(rst8), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .parity_mode(parity8), .two_stop(two_stop8), .tx(tx8), .busy(busy8));

  uart_tx_cfg #(.DATA_W(5), .BAUD_DIV(4)) dut5 (
    .clk(clk), .rst(rst5), .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready5),
    .parity_mode(parity5), .two_stop(two_stop5), .tx(tx5), .busy(busy5));

  // Frame model: index 0 = 8-bit/434 instance, 1 = 5-bit/4 instance.
  logic m_act[2] = '{1'b0, 1'b0};
  int   m_t[2]   = '{0, 0};
  int   m_n[2]   = '{1, 1};
  logic m_bits[2][12];

  always @(posedge clk) begin
    logic r, v, ts, acc;
    logic [8:0] d;
    logic [1:0] pm;
    int dw, bd, ones, n;
    for (int k = 0; k < 2; k++) begin
      r  = (k == 1) ? rst5 : rst8;
      v  = (k == 1) ? tx_valid5 : tx_valid8;
      d  = (k == 1) ? {4'b0, tx_data5} : {1'b0, tx_data8};
      pm = (k == 1) ? parity5 : parity8;
      ts = (k == 1) ? two_stop5 : two_stop8;
      dw = (k == 1) ? 5 : 8;
      bd = (k == 1) ? 4 : 434;
      if (r !== 1'b1) begin
        m_act[k] = 1'b0;
        m_t[k]   = 0;
      end else begin
        acc = v && !m_act[k];
        if (m_act[k]) begin
          m_t[k]++;
          if (m_t[k] == m_n[k] * bd) m_act[k] = 1'b0;
        end
        if (acc) begin
          n = 0;
          ones = 0;
          m_bits[k][n] = 1'b0; n++;
          for (int i = 0; i < dw; i++) begin
            m_bits[k][n] = d[i]; n++;
            if (d[i]) ones++;
          end
          if (pm == 2'b01) begin m_bits[k][n] = (ones % 2 == 1); n++; end
          if (pm == 2'b10) begin m_bits[k][n] = (ones % 2 == 0); n++; end
          m_bits[k][n] = 1'b1; n++;
          if (ts) begin m_bits[k][n] = 1'b1; n++; end
          m_n[k]   = n;
          m_t[k]   = 0;
          m_act[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] got, exp;
    int bd;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bd = (k == 1) ? 4 : 434;
        exp[2] = (m_act[k] && m_t[k] >= 1) ? m_bits[k][(m_t[k] - 1) / bd] : 1'b1;
        exp[1] = m_act[k];
        exp[0] = ((k == 1) ? rst5 : rst8) && !m_act[k];
        got = (k == 1) ? {tx5, busy5, tx_ready5} : {tx8, busy8, tx_ready8};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL cycle_model dut%0d t=%0d {tx,busy,ready} got=%b exp=%b", k, m_t[k], got, exp);
        end
      end
    end
  end

  // Receiver on the 8-bit line: samples mid-bit, keeps the 8 data bits plus the bit that follows them.
  logic [8:0] rxq[$];
  initial begin
    logic [8:0] w;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx8 === 1'b0) begin
        repeat (217) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (434) @(negedge clk);
          w[i] = tx8;
        end
        rxq.push_back(w);
      end
      prev = tx8;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_rdy8();
    int c = 0;
    while (tx_ready8 !== 1'b1 && c < 10000) begin @(posedge clk); #1; c++; end
    chk("ready8_wait", {31'b0, tx_ready8}, 32'd1);
  endtask

  task automatic wait_rdy5();
    int c = 0;
    while (tx_ready5 !== 1'b1 && c < 1000) begin @(posedge clk); #1; c++; end
    chk("ready5_wait", {31'b0, tx_ready5}, 32'd1);
  endtask

  task automatic pop_rx(input string nm, input logic [8:0] exp);
    if (rxq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s got=no_frame exp=%0h", nm, exp);
    end else begin
      chk(nm, {23'b0, rxq.pop_front()}, {23'b0, exp});
    end
  endtask

  task automatic frame8(input string nm, input logic [7:0] d, input logic [1:0] pm, input logic ts,
                        input int exp_low, input logic [8:0] exp_rx);
    int c = 0;
    wait_rdy8();
    tx_data8 = d; parity8 = pm; two_stop8 = ts; tx_valid8 = 1'b1;
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    tx_data8 = ~d; parity8 = ~pm; two_stop8 = ~ts;
    while (tx_ready8 !== 1'b1 && c < 20000) begin @(posedge clk); #1; c++; end
    chk({nm, "_ready_low"}, c, exp_low);
    repeat (10) @(posedge clk); #1;
    pop_rx({nm, "_word"}, exp_rx);
  endtask

  initial begin
    logic [8:0] got5;
    int low5;
    rst8 = 1'b0; tx_valid8 = 1'b0; tx_data8 = '0; parity8 = '0; two_stop8 = 1'b0;
    rst5 = 1'b0; tx_valid5 = 1'b0; tx_data5 = '0; parity5 = '0; two_stop5 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_tx", {31'b0, tx8}, 32'd1);
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_ready_low", {31'b0, tx_ready8}, 32'd0);
    rst8 = 1'b1; rst5 = 1'b1;
    #1;
    chk("ready_after_rst", {31'b0, tx_ready8}, 32'd1);
    @(posedge clk); #1;

    frame8("a5_8n1",   8'hA5, 2'b00, 1'b0, 4340, 9'h1A5);
    frame8("07_even",  8'h07, 2'b01, 1'b0, 4774, 9'h107);
    frame8("07_odd",   8'h07, 2'b10, 1'b0, 4774, 9'h007);
    frame8("00_even2", 8'h00, 2'b01, 1'b1, 5208, 9'h000);

    // back-to-back with valid held; a mid-frame data change must not disturb the frame in flight
    wait_rdy8();
    tx_data8 = 8'h55; parity8 = 2'b00; two_stop8 = 1'b0; tx_valid8 = 1'b1;
    @(posedge clk); #1;
    tx_data8 = 8'hFF;
    for (int c = 1; c <= 4342; c++) begin
      @(posedge clk); #1;
      if (c == 2000) tx_data8 = 8'hAA;
      if (c == 4340) begin
        chk("b2b_last_stop", {31'b0, tx8}, 32'd1);
        chk("b2b_ready_back", {31'b0, tx_ready8}, 32'd1);
      end
      if (c == 4341) begin
        chk("b2b_idle_gap", {31'b0, tx8}, 32'd1);
        chk("b2b_second_accept", {31'b0, tx_ready8}, 32'd0);
        tx_valid8 = 1'b0;
      end
      if (c == 4342) chk("b2b_start2", {31'b0, tx8}, 32'd0);
    end
    wait_rdy8();
    repeat (5) @(posedge clk); #1;
    pop_rx("b2b_word1", 9'h155);
    pop_rx("b2b_word2", 9'h1AA);

    // mid-frame reset on the 5-bit / 4-clock instance during data bit 3
    wait_rdy5();
    tx_data5 = 5'h16; parity5 = 2'b00; two_stop5 = 1'b0; tx_valid5 = 1'b1;
    @(posedge clk); #1;
    tx_valid5 = 1'b0;
    repeat (17) @(posedge clk); #1;
    rst5 = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx", {31'b0, tx5}, 32'd1);
    chk("midrst_busy", {31'b0, busy5}, 32'd0);
    chk("midrst_ready_low", {31'b0, tx_ready5}, 32'd0);
    rst5 = 1'b1;
    #1;
    chk("midrst_ready_high", {31'b0, tx_ready5}, 32'd1);
    @(posedge clk); #1;
    tx_data5 = 5'h0B; parity5 = 2'b01; two_stop5 = 1'b1; tx_valid5 = 1'b1;
    @(posedge clk); #1;
    tx_valid5 = 1'b0;
    got5 = '0;
    low5 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (((c - 1) % 4 == 2) && ((c - 1) / 4 < 9)) got5[(c - 1) / 4] = tx5;
      if (low5 < 0 && tx_ready5 === 1'b1) low5 = c;
    end
    chk("fresh5_bits", {23'b0, got5}, {23'b0, 9'b111010110});
    chk("fresh5_ready_low", low5, 36);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
